// File: rtl/regfile_scoreboard.sv
// Register file with pending-write scoreboard and write-back bypass, sitting
// between issue and write-back; raises stall on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int INDEX_WIDTH = 3,
    parameter int REG_WIDTH   = 32,
    parameter bit ZERO_REG    = 1'b0,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_wr,
    input  logic [INDEX_WIDTH-1:0]   issue_rd,
    input  logic [INDEX_WIDTH-1:0]   rs1,
    input  logic [INDEX_WIDTH-1:0]   rs2,
    output logic [REG_WIDTH-1:0]     S1,
    output logic [REG_WIDTH-1:0]     S2,
    output logic                     stall,
    input  logic                     wb_we,
    input  logic [INDEX_WIDTH-1:0]   wb_rd,
    input  logic [REG_WIDTH-1:0]     wb_data,
    output logic [(1<<INDEX_WIDTH)-1:0] busy,
    output logic [INDEX_WIDTH:0]     pending
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] IDX_ZERO = {INDEX_WIDTH{1'b0}};

    logic [REG_WIDTH-1:0]   regs_r [DEPTH];
    logic [DEPTH-1:0]       busy_r;
    logic [INDEX_WIDTH:0]   pending_r;

    logic [REG_WIDTH-1:0]   s1_s;
    logic [REG_WIDTH-1:0]   s2_s;
    logic                   fwd1_s;
    logic                   fwd2_s;
    logic                   haz1_s;
    logic                   haz2_s;
    logic                   waw_s;
    logic                   stall_s;
    logic                   wb_ok_s;
    logic                   iss_ok_s;
    logic [DEPTH-1:0]       busy_next_s;

    function automatic logic [INDEX_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
        logic [INDEX_WIDTH:0] c;
        c = {(INDEX_WIDTH+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{INDEX_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Read ports: hardwired zero beats bypass, bypass beats the array
    always_comb begin
        fwd1_s = BYPASS && wb_we && (wb_rd == rs1);
        fwd2_s = BYPASS && wb_we && (wb_rd == rs2);
        if (ZERO_REG && (rs1 == IDX_ZERO)) begin
            s1_s = {REG_WIDTH{1'b0}};
        end else if (fwd1_s) begin
            s1_s = wb_data;
        end else begin
            s1_s = regs_r[rs1];
        end
        if (ZERO_REG && (rs2 == IDX_ZERO)) begin
            s2_s = {REG_WIDTH{1'b0}};
        end else if (fwd2_s) begin
            s2_s = wb_data;
        end else begin
            s2_s = regs_r[rs2];
        end
    end

    // Hazard detection; stall is built only from inputs and state
    always_comb begin
        haz1_s  = busy_r[rs1] && !fwd1_s;
        haz2_s  = busy_r[rs2] && !fwd2_s;
        waw_s   = issue_wr && busy_r[issue_rd] && !(wb_we && (wb_rd == issue_rd));
        stall_s = issue_valid && (haz1_s || haz2_s || waw_s);
    end

    // Next busy vector: WB clears first so a same-index accepted issue wins
    always_comb begin
        wb_ok_s     = wb_we && !(ZERO_REG && (wb_rd == IDX_ZERO));
        iss_ok_s    = issue_valid && !stall_s && issue_wr &&
                      !(ZERO_REG && (issue_rd == IDX_ZERO));
        busy_next_s = busy_r;
        if (wb_ok_s) begin
            busy_next_s[wb_rd] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (iss_ok_s) begin
            busy_next_s[issue_rd] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Scoreboard state and its population count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= {DEPTH{1'b0}};
            pending_r <= {(INDEX_WIDTH+1){1'b0}};
        end else begin
            busy_r    <= busy_next_s;
            pending_r <= popcount(busy_next_s);
        end
    end

    // Register array write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {REG_WIDTH{1'b0}};
            end
        end else if (wb_ok_s) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    assign S1      = s1_s;
    assign S2      = s2_s;
    assign stall   = stall_s;
    assign busy    = busy_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: three parameterisations share one stimulus bus; a vector
// table covers read/stall combinations, hand sequences cover multi-cycle cases.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_wr;
    logic [2:0]  issue_rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] a_s1, a_s2, b_s1, b_s2, c_s1, c_s2;
    logic        a_stall, b_stall, c_stall;
    logic [7:0]  a_busy, b_busy, c_busy;
    logic [3:0]  a_pend, b_pend, c_pend;

    int tests;
    int failures;

    // a: bypass on, R0 ordinary
    regfile_scoreboard #(.INDEX_WIDTH(3), .REG_WIDTH(32), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .S1(a_s1), .S2(a_s2),
        .stall(a_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(a_busy), .pending(a_pend));

    // b: bypass off
    regfile_scoreboard #(.INDEX_WIDTH(3), .REG_WIDTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .S1(b_s1), .S2(b_s2),
        .stall(b_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(b_busy), .pending(b_pend));

    // c: hardwired R0
    regfile_scoreboard #(.INDEX_WIDTH(3), .REG_WIDTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .S1(c_s1), .S2(c_s2),
        .stall(c_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(c_busy), .pending(c_pend));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        iw;
        logic [2:0]  rd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic        we;
        logic [2:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        est;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_rd    = 3'd0;
        rs1         = 3'd0;
        rs2         = 3'd0;
        wb_we       = 1'b0;
        wb_rd       = 3'd0;
        wb_data     = 32'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wb(input logic [2:0] rd, input logic [31:0] d);
        idle();
        wb_we = 1'b1; wb_rd = rd; wb_data = d;
        cyc();
    endtask

    task automatic issue(input logic [2:0] rd, input logic [2:0] src);
        idle();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd; rs1 = src; rs2 = src;
        cyc();
    endtask

    initial begin
        logic [7:0] exp_busy;
        logic [2:0] order [8];
        tests = 0;
        failures = 0;
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rs1 = 3'd2;
        #1;
        check("rst_busy", {56'd0, a_busy}, 64'h0);
        check("rst_pending", {60'd0, a_pend}, 64'h0);
        check("rst_stall", {63'd0, a_stall}, 64'h0);
        check("rst_s1", {32'd0, a_s1}, 64'h0);
        rst = 1'b0;
        cyc();

        // --- table: R1=11 R2=22 R3=33 R5=55, busy {3,6} ---
        wb(3'd1, 32'h11);
        wb(3'd2, 32'h22);
        wb(3'd3, 32'h33);
        wb(3'd5, 32'h55);
        issue(3'd3, 3'd0);
        issue(3'd6, 3'd0);
        idle();
        #1;
        check("tbl_busy_pre", {56'd0, a_busy}, 64'h48);
        check("tbl_pend_pre", {60'd0, a_pend}, 64'h2);

        vecs[0]  = '{1'b0,1'b0,3'd0,3'd1,3'd2,1'b0,3'd0,32'h0,    32'h11,  32'h22,1'b0};
        vecs[1]  = '{1'b1,1'b0,3'd0,3'd3,3'd1,1'b0,3'd0,32'h0,    32'h33,  32'h11,1'b1};
        vecs[2]  = '{1'b1,1'b0,3'd0,3'd1,3'd6,1'b0,3'd0,32'h0,    32'h11,  32'h0, 1'b1};
        vecs[3]  = '{1'b1,1'b1,3'd3,3'd1,3'd2,1'b0,3'd0,32'h0,    32'h11,  32'h22,1'b1};
        vecs[4]  = '{1'b1,1'b1,3'd4,3'd5,3'd2,1'b0,3'd0,32'h0,    32'h55,  32'h22,1'b0};
        vecs[5]  = '{1'b1,1'b0,3'd0,3'd3,3'd1,1'b1,3'd3,32'hAAAA, 32'hAAAA,32'h11,1'b0};
        vecs[6]  = '{1'b1,1'b0,3'd0,3'd3,3'd6,1'b1,3'd3,32'hAAAA, 32'hAAAA,32'h0, 1'b1};
        vecs[7]  = '{1'b1,1'b1,3'd6,3'd0,3'd0,1'b1,3'd6,32'h66,   32'h0,   32'h0, 1'b0};
        vecs[8]  = '{1'b0,1'b0,3'd0,3'd0,3'd2,1'b1,3'd0,32'h77,   32'h77,  32'h22,1'b0};
        vecs[9]  = '{1'b0,1'b0,3'd0,3'd7,3'd5,1'b1,3'd5,32'h99,   32'h0,   32'h99,1'b0};
        vecs[10] = '{1'b1,1'b1,3'd3,3'd2,3'd2,1'b1,3'd3,32'hBB,   32'h22,  32'h22,1'b0};

        // each vector lives only in the low clock phase so no edge sees it
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            issue_valid = vecs[i].iv; issue_wr = vecs[i].iw; issue_rd = vecs[i].rd;
            rs1 = vecs[i].r1; rs2 = vecs[i].r2;
            wb_we = vecs[i].we; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_s1", i), {32'd0, a_s1}, {32'd0, vecs[i].e1});
            check($sformatf("vec%0d_s2", i), {32'd0, a_s2}, {32'd0, vecs[i].e2});
            check($sformatf("vec%0d_stall", i), {63'd0, a_stall}, {63'd0, vecs[i].est});
            #1;
            idle();
        end
        cyc();
        check("tbl_busy_post", {56'd0, a_busy}, 64'h48);

        // --- asynchronous reset mid-cycle ---
        do_reset();
        wb(3'd2, 32'h1234);
        issue(3'd0, 3'd1);
        issue(3'd2, 3'd1);
        idle();
        rs1 = 3'd2;
        #1;
        check("arst_busy_pre", {56'd0, a_busy}, 64'h05);
        check("arst_s1_pre", {32'd0, a_s1}, 64'h1234);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", {56'd0, a_busy}, 64'h0);
        check("arst_pending", {60'd0, a_pend}, 64'h0);
        check("arst_s1", {32'd0, a_s1}, 64'h0);
        cyc();
        rst = 1'b0;

        // --- RAW stall then write-back, with and without bypass ---
        idle();
        cyc();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 3'd3;
        #1;
        check("raw_issue_stall_a", {63'd0, a_stall}, 64'h0);
        cyc();
        issue_wr = 1'b0; issue_rd = 3'd0; rs1 = 3'd3;
        #1;
        check("raw_stall_a", {63'd0, a_stall}, 64'h1);
        check("raw_stall_b", {63'd0, b_stall}, 64'h1);
        check("raw_busy_a", {56'd0, a_busy}, 64'h08);
        check("raw_pend_a", {60'd0, a_pend}, 64'h1);
        cyc();
        wb_we = 1'b1; wb_rd = 3'd3; wb_data = 32'hDEADBEEF;
        #1;
        check("raw_wb_stall_a", {63'd0, a_stall}, 64'h0);
        check("raw_wb_s1_a", {32'd0, a_s1}, 64'hDEADBEEF);
        check("raw_wb_stall_b", {63'd0, b_stall}, 64'h1);
        cyc();
        wb_we = 1'b0; wb_rd = 3'd0; wb_data = 32'd0;
        #1;
        check("raw_after_busy_a", {56'd0, a_busy}, 64'h0);
        check("raw_after_pend_a", {60'd0, a_pend}, 64'h0);
        check("raw_after_stall_b", {63'd0, b_stall}, 64'h0);
        check("raw_after_s1_b", {32'd0, b_s1}, 64'hDEADBEEF);

        // --- WAW, then resolved by same-cycle write-back ---
        do_reset();
        issue(3'd5, 3'd1);
        idle();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 3'd5; rs1 = 3'd1; rs2 = 3'd1;
        #1;
        check("waw_stall", {63'd0, a_stall}, 64'h1);
        wb_we = 1'b1; wb_rd = 3'd5; wb_data = 32'h5555;
        #1;
        check("waw_wb_stall", {63'd0, a_stall}, 64'h0);
        cyc();
        idle();
        rs1 = 3'd5;
        #1;
        check("waw_busy", {56'd0, a_busy}, 64'h20);
        check("waw_pend", {60'd0, a_pend}, 64'h1);
        check("waw_s1", {32'd0, a_s1}, 64'h5555);

        // --- hardwired R0 versus ordinary R0 ---
        do_reset();
        wb_we = 1'b1; wb_rd = 3'd0; wb_data = 32'hFFFF;
        #1;
        check("zr_bypass_c", {32'd0, c_s1}, 64'h0);
        check("zr_bypass_a", {32'd0, a_s1}, 64'hFFFF);
        cyc();
        idle();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 3'd0; rs1 = 3'd1; rs2 = 3'd1;
        #1;
        check("zr_issue_stall_c", {63'd0, c_stall}, 64'h0);
        cyc();
        idle();
        #1;
        check("zr_s1_c", {32'd0, c_s1}, 64'h0);
        check("zr_busy_c", {56'd0, c_busy}, 64'h0);
        check("zr_pend_c", {60'd0, c_pend}, 64'h0);
        check("zr_s1_a", {32'd0, a_s1}, 64'hFFFF);
        check("zr_busy_a", {56'd0, a_busy}, 64'h01);

        // --- fill every register, then retire in scrambled order ---
        do_reset();
        for (int r = 0; r < 8; r++) begin
            idle();
            issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = r[2:0]; rs1 = 3'd7; rs2 = 3'd7;
            #1;
            check($sformatf("fill%0d_stall", r), {63'd0, a_stall}, 64'h0);
            cyc();
            check($sformatf("fill%0d_pend", r), {60'd0, a_pend}, r + 1);
        end
        idle();
        check("fill_busy", {56'd0, a_busy}, 64'hFF);
        check("fill_pend", {60'd0, a_pend}, 64'h8);
        order[0] = 3'd5; order[1] = 3'd2; order[2] = 3'd7; order[3] = 3'd0;
        order[4] = 3'd3; order[5] = 3'd6; order[6] = 3'd1; order[7] = 3'd4;
        exp_busy = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            wb(order[k], 32'h100 + k);
            exp_busy[order[k]] = 1'b0;
            check($sformatf("drain%0d_pend", k), {60'd0, a_pend}, 7 - k);
            check($sformatf("drain%0d_busy", k), {56'd0, a_busy}, {56'd0, exp_busy});
        end
        idle();
        check("drain_busy_end", {56'd0, a_busy}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
